// File: rtl/unix_to_calendar.sv
// Iterative Unix-timestamp to local calendar converter: a restoring divide by 86400
// followed by subtract loops for hours, minutes, years and months.
module unix_to_calendar #(
  parameter int          TZ_OFFSET_SEC = 28800,
  parameter int unsigned MIN_VALID     = 32'd1704067200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] unix_time,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic [2:0]  weekday
);

  localparam logic [31:0] TzVec      = TZ_OFFSET_SEC;
  localparam logic [31:0] MinValid   = MIN_VALID;
  localparam logic [17:0] SecPerDay  = 18'd86400;

  typedef enum logic [2:0] {StIdle, StDiv, StHr, StMn, StYr, StMo, StFin} state_e;

  state_e      state_q;
  logic [31:0] dvd_q;
  logic [16:0] rem_q;   // division remainder, then seconds-of-day
  logic [4:0]  cnt_q;
  logic [16:0] days_q;
  logic [4:0]  hr_q;
  logic [5:0]  mn_q;
  logic [11:0] yr_q;
  logic [3:0]  mo_q;
  logic [2:0]  wd_q;
  logic        valid_next_q;

  logic [33:0] t_sum;
  logic [31:0] t_sat;
  logic [17:0] trial;
  logic        trial_ge;
  logic [17:0] trial_sub;
  logic [31:0] dvd_nx;
  logic [16:0] rem_nx;
  logic        leap;
  logic [8:0]  ylen;
  logic [4:0]  dim;
  logic [2:0]  dim_mod7;
  logic [3:0]  wd_yr;
  logic [3:0]  wd_mo;
  logic [5:0]  wd_fin;

  always_comb begin
    t_sum = {2'b00, unix_time} + {{2{TzVec[31]}}, TzVec};
    if (t_sum[33])      t_sat = 32'd0;
    else if (t_sum[32]) t_sat = 32'hFFFF_FFFF;
    else                t_sat = t_sum[31:0];

    trial     = {rem_q, dvd_q[31]};
    trial_ge  = trial >= SecPerDay;
    trial_sub = trial - SecPerDay;
    dvd_nx    = {dvd_q[30:0], trial_ge};
    rem_nx    = trial_ge ? trial_sub[16:0] : trial[16:0];

    leap = (yr_q[1:0] == 2'b00) && (yr_q != 12'd2100);
    ylen = leap ? 9'd366 : 9'd365;

    unique case (mo_q)
      4'd2:                      dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
      default:                   dim = 5'd31;
    endcase
    unique case (dim)
      5'd28:   dim_mod7 = 3'd0;
      5'd29:   dim_mod7 = 3'd1;
      5'd30:   dim_mod7 = 3'd2;
      default: dim_mod7 = 3'd3;
    endcase

    wd_yr = {1'b0, wd_q} + (leap ? 4'd2 : 4'd1);
    if (wd_yr >= 4'd7) wd_yr = wd_yr - 4'd7;
    wd_mo = {1'b0, wd_q} + {1'b0, dim_mod7};
    if (wd_mo >= 4'd7) wd_mo = wd_mo - 4'd7;

    // days is below 31 here, so the sum is at most 36
    wd_fin = {3'b000, wd_q} + days_q[5:0];
    for (int i = 0; i < 5; i++) begin
      if (wd_fin >= 6'd7) wd_fin = wd_fin - 6'd7;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      dvd_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      days_q       <= '0;
      hr_q         <= '0;
      mn_q         <= '0;
      yr_q         <= 12'd1970;
      mo_q         <= 4'd1;
      wd_q         <= 3'd4;
      valid_next_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      year         <= 12'd1970;
      month        <= 4'd1;
      day          <= 5'd1;
      hour         <= '0;
      minute       <= '0;
      second       <= '0;
      weekday      <= 3'd4;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q        <= t_sat;
            rem_q        <= '0;
            cnt_q        <= '0;
            valid_next_q <= unix_time >= MinValid;
            busy         <= 1'b1;
            state_q      <= StDiv;
          end
        end
        StDiv: begin
          dvd_q <= dvd_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            days_q  <= dvd_nx[16:0];
            hr_q    <= '0;
            yr_q    <= 12'd1970;
            wd_q    <= 3'd4;
            state_q <= StHr;
          end
        end
        StHr: begin
          if (rem_q >= 17'd3600) begin
            rem_q <= rem_q - 17'd3600;
            hr_q  <= hr_q + 5'd1;
          end else begin
            mn_q    <= '0;
            state_q <= StMn;
          end
        end
        StMn: begin
          if (rem_q >= 17'd60) begin
            rem_q <= rem_q - 17'd60;
            mn_q  <= mn_q + 6'd1;
          end else begin
            state_q <= StYr;
          end
        end
        StYr: begin
          if (days_q >= {8'd0, ylen}) begin
            days_q <= days_q - {8'd0, ylen};
            yr_q   <= yr_q + 12'd1;
            wd_q   <= wd_yr[2:0];
          end else begin
            mo_q    <= 4'd1;
            state_q <= StMo;
          end
        end
        StMo: begin
          if (days_q >= {12'd0, dim}) begin
            days_q <= days_q - {12'd0, dim};
            mo_q   <= mo_q + 4'd1;
            wd_q   <= wd_mo[2:0];
          end else begin
            state_q <= StFin;
          end
        end
        StFin: begin
          year    <= yr_q;
          month   <= mo_q;
          day     <= days_q[4:0] + 5'd1;
          hour    <= hr_q;
          minute  <= mn_q;
          second  <= rem_q[5:0];
          weekday <= wd_fin[2:0];
          valid   <= valid_next_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unix_to_calendar.sv
// Directed bench for unix_to_calendar: known dates, saturation, handshake and reset abort.
module tb_unix_to_calendar;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] unix_time = '0;
  logic        busy, done, valid;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic [2:0]  weekday;

  int errors = 0;
  int checks = 0;

  unix_to_calendar dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .unix_time (unix_time),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .year      (year),
    .month     (month),
    .day       (day),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .weekday   (weekday)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] pack(input int y, input int mo, input int d, input int h,
                                       input int mi, input int s, input int w, input int v);
    pack = {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s), 3'(w), 1'(v)};
  endfunction

  logic [41:0] obs;
  always_comb obs = {year, month, day, hour, minute, second, weekday, valid};

  // Pulse start, then wait (bounded) for done; sampled on negedges.
  task automatic run_conv(input logic [31:0] ut, output bit seen, output int lat);
    @(negedge clk);
    start = 1'b1;
    unix_time = ut;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    lat = 1;
    while (!seen && lat < 300) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (obs !== pack(1970, 1, 1, 0, 0, 0, 4, 0)) begin
      errors++;
      $display("FAIL reset_fields: got %h required %h", obs, pack(1970, 1, 1, 0, 0, 0, 4, 0));
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_epoch();
    bit seen;
    int lat;
    @(negedge clk);
    start = 1'b1;
    unix_time = 32'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL epoch_busy: got %b required 1", busy);
    end
    seen = 1'b0;
    lat = 1;
    while (!seen && lat < 300) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL epoch_done: no done within 300 cycles");
    end
    checks++;
    if (obs !== pack(1970, 1, 1, 8, 0, 0, 4, 0)) begin
      errors++;
      $display("FAIL epoch_fields: got %h required %h", obs, pack(1970, 1, 1, 8, 0, 0, 4, 0));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL epoch_done_width: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_vector(input string name, input logic [31:0] ut, input logic [41:0] exp);
    bit seen;
    int lat;
    run_conv(ut, seen, lat);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: no done within 300 cycles", name);
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s_fields: got %h required %h", name, obs, exp);
    end
  endtask

  task automatic test_saturation();
    bit seen;
    int lat;
    run_conv(32'hFFFF_FFFF, seen, lat);
    checks++;
    if (!seen || lat > 270) begin
      errors++;
      $display("FAIL sat_latency: seen=%b latency=%0d required done within 270", seen, lat);
    end
    checks++;
    if (obs !== pack(2106, 2, 7, 6, 28, 15, 0, 1)) begin
      errors++;
      $display("FAIL sat_fields: got %h required %h", obs, pack(2106, 2, 7, 6, 28, 15, 0, 1));
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int lat;
    @(negedge clk);
    start = 1'b1;
    unix_time = 32'd1725868800;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    unix_time = 32'd0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 300) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || obs !== pack(2024, 9, 9, 16, 0, 0, 1, 1)) begin
      errors++;
      $display("FAIL busy_start_ignored: seen=%b got %h required %h", seen, obs,
               pack(2024, 9, 9, 16, 0, 0, 1, 1));
    end
    // a second done would mean the ignored start was queued
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL busy_start_queued: got extra done required none");
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    start = 1'b1;
    unix_time = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (obs !== pack(1970, 1, 1, 0, 0, 0, 4, 0)) begin
      errors++;
      $display("FAIL abort_fields: got %h required %h", obs, pack(1970, 1, 1, 0, 0, 0, 4, 0));
    end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: saw done/busy after reset required none");
    end
  endtask

  initial begin
    test_reset();
    test_epoch();
    test_vector("nominal", 32'd1725868800, pack(2024, 9, 9, 16, 0, 0, 1, 1));
    test_vector("leap0", 32'd1709136000, pack(2024, 2, 29, 0, 0, 0, 4, 1));
    test_vector("leap1", 32'd1709222399, pack(2024, 2, 29, 23, 59, 59, 4, 1));
    test_vector("yend", 32'd1735660799, pack(2024, 12, 31, 23, 59, 59, 2, 1));
    test_vector("ystart", 32'd1735660800, pack(2025, 1, 1, 0, 0, 0, 3, 1));
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
